// File: rtl/serial_half_mixer.sv
// Column-serial half-round mixer: right_out = L ^ rho (^ K), left_out = R, one column per cycle.
// Key addition is built only when SERIAL_MIX_KEY_EN is defined.
module serial_half_mixer #(
    parameter int unsigned BLOCK_SIZE  = 256,
    parameter int unsigned SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int unsigned COLUMN_SIZE = SIDE_SIZE / 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:SIDE_SIZE-1] left_in,
    input  logic [0:SIDE_SIZE-1] right_in,
    input  logic [0:SIDE_SIZE-1] rho_in,
    input  logic [0:SIDE_SIZE-1] key_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] left_out,
    output logic [0:SIDE_SIZE-1] right_out,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(SIDE_SIZE);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [1:0]           col_q;
    logic [0:SIDE_SIZE-1] l_q;
    logic [0:SIDE_SIZE-1] r_q;
    logic [0:SIDE_SIZE-1] rho_q;
    logic [0:SIDE_SIZE-1] res_q;
    logic [0:SIDE_SIZE-1] res_d;
    logic [IDX_W-1:0]     base;

`ifdef SERIAL_MIX_KEY_EN
    logic [0:SIDE_SIZE-1] k_q;
`else
    logic unused_key;
    assign unused_key = ^key_in;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (col_q == 2'd3) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result register with the current column replaced by its mixed value
    always_comb begin
        base  = IDX_W'(col_q) * IDX_W'(COLUMN_SIZE);
        res_d = res_q;
`ifdef SERIAL_MIX_KEY_EN
        res_d[base +: COLUMN_SIZE] = l_q[base +: COLUMN_SIZE] ^ rho_q[base +: COLUMN_SIZE]
                                   ^ k_q[base +: COLUMN_SIZE];
`else
        res_d[base +: COLUMN_SIZE] = l_q[base +: COLUMN_SIZE] ^ rho_q[base +: COLUMN_SIZE];
`endif
    end

    // State, handshake flags and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            col_q     <= 2'd0;
            l_q       <= '0;
            r_q       <= '0;
            rho_q     <= '0;
            res_q     <= '0;
            left_out  <= '0;
            right_out <= '0;
`ifdef SERIAL_MIX_KEY_EN
            k_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d == BUSY);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q   <= left_in;
                        r_q   <= right_in;
                        rho_q <= rho_in;
                        col_q <= 2'd0;
`ifdef SERIAL_MIX_KEY_EN
                        k_q   <= key_in;
`endif
                    end
                end
                BUSY: begin
                    res_q <= res_d;
                    col_q <= col_q + 2'd1;
                    // Outputs only change when the last column lands
                    if (col_q == 2'd3) begin
                        left_out  <= r_q;
                        right_out <= res_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_half_mixer.sv
// Randomized self-checking bench for serial_half_mixer against a whole-vector XOR model.
module tb_serial_half_mixer;

    localparam int SIDE = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [0:SIDE-1] left_in;
    logic [0:SIDE-1] right_in;
    logic [0:SIDE-1] rho_in;
    logic [0:SIDE-1] key_in;
    logic            out_valid;
    logic            out_ready;
    logic [0:SIDE-1] left_out;
    logic [0:SIDE-1] right_out;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_half_mixer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left_in   (left_in),
        .right_in  (right_in),
        .rho_in    (rho_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .left_out  (left_out),
        .right_out (right_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [SIDE-1:0] got, input logic [SIDE-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:SIDE-1] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: the half-round is a plain XOR of whole halves
    function automatic logic [0:SIDE-1] model_right(input logic [0:SIDE-1] l, input logic [0:SIDE-1] rh,
                                                   input logic [0:SIDE-1] k);
`ifdef SERIAL_MIX_KEY_EN
        return l ^ rh ^ k;
`else
        return l ^ rh ^ (k & '0);
`endif
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom);
        left_in  = rnd();
        right_in = rnd();
        rho_in   = rnd();
        key_in   = rnd();
    endtask

    task automatic accept_op(input logic [0:SIDE-1] l, input logic [0:SIDE-1] r,
                             input logic [0:SIDE-1] rh, input logic [0:SIDE-1] k);
        left_in  = l;
        right_in = r;
        rho_in   = rh;
        key_in   = k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        left_in  = rnd();
        right_in = rnd();
        rho_in   = rnd();
        key_in   = rnd();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, SIDE'(in_ready), SIDE'(1'b1));
        check({tag, "_out_valid"}, SIDE'(out_valid), '0);
        check({tag, "_busy"}, SIDE'(busy), '0);
        check({tag, "_left"}, left_out, '0);
        check({tag, "_right"}, right_out, '0);
    endtask

    // Full transaction: accept, 4 busy cycles, DONE held for `hold` cycles, then handshake
    task automatic run_op(input logic [0:SIDE-1] l, input logic [0:SIDE-1] r,
                          input logic [0:SIDE-1] rh, input logic [0:SIDE-1] k,
                          input logic [0:SIDE-1] exp_r, input int hold);
        check("idle_ready", SIDE'(in_ready), SIDE'(1'b1));
        out_ready = 1'b0;
        accept_op(l, r, rh, k);
        for (int i = 0; i < 4; i++) begin
            check("busy_flag", SIDE'(busy), SIDE'(1'b1));
            check("busy_in_ready", SIDE'(in_ready), '0);
            check("busy_out_valid", SIDE'(out_valid), '0);
            scramble_inputs();
            if (i == 3) out_ready = (hold == 0);
            tick();
        end
        check("done_out_valid", SIDE'(out_valid), SIDE'(1'b1));
        check("done_in_ready", SIDE'(in_ready), '0);
        check("done_busy", SIDE'(busy), '0);
        check("done_left", left_out, r);
        check("done_right", right_out, exp_r);
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            out_ready = 1'b0;
            tick();
            check("hold_out_valid", SIDE'(out_valid), SIDE'(1'b1));
            check("hold_in_ready", SIDE'(in_ready), '0);
            check("hold_left", left_out, r);
            check("hold_right", right_out, exp_r);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_out_valid", SIDE'(out_valid), '0);
        check("post_in_ready", SIDE'(in_ready), SIDE'(1'b1));
        check("post_left_held", left_out, r);
        check("post_right_held", right_out, exp_r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:SIDE-1] l, r, rh, k, ones, exp_r;
        int prev_t;
        bit found;

        // Reset wins over a simultaneous in_valid
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        left_in   = rnd();
        right_in  = rnd();
        rho_in    = rnd();
        key_in    = rnd();
        tick();
        tick();
        check_reset_state("reset");
        rst      = 1'b0;
        in_valid = 1'b0;

        ones = '1;
        run_op('0, ones, '0, '0, '0, 0);

        l  = 128'h00000001_00000002_00000003_00000004;
        rh = 128'h10000000_20000000_30000000_40000000;
        k  = 128'hFFFFFFFF_00000000_00000000_00000000;
        r  = rnd();
`ifdef SERIAL_MIX_KEY_EN
        exp_r = 128'hEFFFFFFE_20000002_30000003_40000004;
`else
        exp_r = 128'h10000001_20000002_30000003_40000004;
`endif
        run_op(l, r, rh, k, exp_r, 10);

        for (int n = 0; n < 8; n++) begin
            l  = rnd();
            r  = rnd();
            rh = rnd();
            k  = rnd();
            run_op(l, r, rh, k, model_right(l, rh, k), int'($urandom_range(3)));
        end

        // Reset on the second busy cycle aborts the operation
        accept_op(rnd(), rnd(), rnd(), rnd());
        tick();
        check("midbusy_busy", SIDE'(busy), SIDE'(1'b1));
        rst = 1'b1;
        tick();
        check_reset_state("midbusy_rst");
        rst = 1'b0;
        l  = rnd();
        r  = rnd();
        rh = rnd();
        k  = rnd();
        run_op(l, r, rh, k, model_right(l, rh, k), 1);

        // Reset while DONE drops the presented result
        accept_op(rnd(), rnd(), rnd(), rnd());
        for (int i = 0; i < 4; i++) tick();
        check("done_rst_pre_valid", SIDE'(out_valid), SIDE'(1'b1));
        rst = 1'b1;
        tick();
        check_reset_state("done_rst");
        rst = 1'b0;

        // Back-to-back with in_valid and out_ready held high
        prev_t    = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            l  = rnd();
            r  = rnd();
            rh = rnd();
            k  = rnd();
            left_in  = l;
            right_in = r;
            rho_in   = rh;
            key_in   = k;
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick();
                if (out_valid) found = 1'b1;
            end
            check("b2b_seen", SIDE'(found), SIDE'(1'b1));
            check("b2b_left", left_out, r);
            check("b2b_right", right_out, model_right(l, rh, k));
            if (n > 0) check("b2b_spacing", SIDE'(cyc - prev_t), SIDE'(6));
            prev_t = cyc;
        end
        in_valid = 1'b0;
        tick();
        check("b2b_end_out_valid", SIDE'(out_valid), '0);
        check("b2b_end_in_ready", SIDE'(in_ready), SIDE'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
